// File: rtl/la_iorxdiff_pkg.sv
// Shared types and limits for the la_iorxdiff_sync differential receiver.
package la_iorxdiff_pkg;

  // Pad ring side encodings.
  typedef enum logic [1:0] {
    SideNo,
    SideSo,
    SideEa,
    SideWe
  } side_e;

  // Legal synchronizer depth range.
  localparam int unsigned SyncMin = 2;
  localparam int unsigned SyncMax = 4;

  // Storage widths for the per-lane counters. FILTW must not exceed CntW, and
  // FLTLEN must fit in IcntW bits.
  localparam int unsigned CntW  = 8;
  localparam int unsigned IcntW = 16;

  typedef struct packed {
    logic [CntW-1:0]  cnt;
    logic [IcntW-1:0] icnt;
    logic             z;
    logic             fault;
  } lane_state_t;

  // Map the SIDE string parameter onto an encoding. Unknown strings fall back to north.
  function automatic side_e side_decode(input string side);
    if (side == "SO") return SideSo;
    if (side == "EA") return SideEa;
    if (side == "WE") return SideWe;
    return SideNo;
  endfunction

endpackage

// File: rtl/la_iobidir.sv
// Behavioural bidirectional pad cell: tristate output driver plus gated input buffer.
module la_iobidir
  import la_iorxdiff_pkg::*;
#(
  parameter string       PROP  = "DEFAULT",
  parameter string       SIDE  = "NO",
  parameter int unsigned CFGW  = 16,
  parameter int unsigned RINGW = 8
) (
  inout  wire              pad_io,
  inout  wire              vdd_io,
  inout  wire              vss_io,
  inout  wire              vddio_io,
  inout  wire              vssio_io,
  inout  wire  [RINGW-1:0] ioring_io,
  input  logic [CFGW-1:0]  cfg_i,
  input  logic             a_i,
  input  logic             oe_i,
  input  logic             ie_i,
  output logic             z_o
);

  localparam side_e Side        = side_decode(SIDE);
  localparam logic  PropDefault = (PROP == "DEFAULT");

  assign pad_io = oe_i ? a_i : 1'bz;
  // Input buffer output is forced low when the receiver is disabled.
  assign z_o    = ie_i & pad_io;

  // Supplies, ring and config only matter to a physical cell.
  logic unused_pad;
  assign unused_pad = ^{vdd_io, vss_io, vddio_io, vssio_io, ioring_io, cfg_i, Side, PropDefault};

endmodule

// File: rtl/la_iorxdiff_lane.sv
// One receiver lane: synchronizer, differential decode, glitch filter and
// persistent-invalid fault detector. Optional rise/fall pulses under
// LA_IORXDIFF_SYNC_EDGE_EN.
module la_iorxdiff_lane
  import la_iorxdiff_pkg::*;
#(
  parameter int unsigned SYNC   = 2,
  parameter int unsigned FILTW  = 4,
  parameter int unsigned FLTLEN = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rp_i,
  input  logic             rn_i,
  input  logic             ie_i,
  input  logic             invert_i,
  input  logic [FILTW-1:0] filtlen_i,
  output logic             z_o,
  output logic             fault_o
`ifdef LA_IORXDIFF_SYNC_EDGE_EN
  ,
  output logic             rise_o,
  output logic             fall_o
`endif
);

  // Out-of-range depths are clamped to the legal range.
  localparam int unsigned SyncDepth = (SYNC < SyncMin) ? SyncMin :
                                      (SYNC > SyncMax) ? SyncMax : SYNC;
  localparam logic [IcntW-1:0] FltLen = IcntW'(FLTLEN);

  logic [SyncDepth-1:0] syncp_q, syncn_q;
  lane_state_t          st_q, st_d;
  logic                 sp, sn, valid, d;
  logic [CntW-1:0]      filt_len;

  // Synchronizer chains; they keep sampling regardless of ie_i.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      syncp_q <= '0;
      syncn_q <= '0;
    end else begin
      syncp_q <= {syncp_q[SyncDepth-2:0], rp_i};
      syncn_q <= {syncn_q[SyncDepth-2:0], rn_i};
    end
  end

  assign sp       = syncp_q[SyncDepth-1];
  assign sn       = syncn_q[SyncDepth-1];
  assign valid    = sp ^ sn;
  assign d        = sp ^ invert_i;
  assign filt_len = CntW'(filtlen_i);

  // Filter and fault next state; cnt >= L lets a shrunk L take effect at once.
  always_comb begin
    st_d = st_q;
    if (!ie_i) begin
      st_d = '0;
    end else if (!valid) begin
      st_d.cnt = '0;
      if (st_q.icnt != FltLen) begin
        st_d.icnt = st_q.icnt + IcntW'(1);
      end
      st_d.fault = (st_d.icnt == FltLen);
    end else begin
      st_d.icnt  = '0;
      st_d.fault = 1'b0;
      if (d != st_q.z) begin
        if (st_q.cnt >= filt_len) begin
          st_d.z   = d;
          st_d.cnt = '0;
        end else begin
          st_d.cnt = st_q.cnt + CntW'(1);
        end
      end else begin
        st_d.cnt = '0;
      end
    end
  end

  // Lane state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign z_o     = st_q.z;
  assign fault_o = st_q.fault;

`ifdef LA_IORXDIFF_SYNC_EDGE_EN
  logic rise_q, fall_q;

  // Edge pulses registered alongside z so they coincide with the z change.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= ie_i & ~st_q.z & st_d.z;
      fall_q <= ie_i & st_q.z & ~st_d.z;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/la_iorxdiff_sync.sv
// Multi-lane synchronizing differential receiver: 2N input-only pad cells
// feeding N independent filter/fault lanes. Define LA_IORXDIFF_SYNC_EDGE_EN
// to add registered rise/fall pulse outputs.
module la_iorxdiff_sync
  import la_iorxdiff_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned FILTW  = 4,
  parameter int unsigned FLTLEN = 8,
  parameter string       PROP   = "DEFAULT",
  parameter string       SIDE   = "NO",
  parameter int unsigned CFGW   = 16,
  parameter int unsigned RINGW  = 8
) (
  input  logic              clk,
  input  logic              nreset,
  inout  wire  [N-1:0]      padp_io,
  inout  wire  [N-1:0]      padn_io,
  inout  wire               vdd_io,
  inout  wire               vss_io,
  inout  wire               vddio_io,
  inout  wire               vssio_io,
  inout  wire  [RINGW-1:0]  ioring_io,
  input  logic [N*CFGW-1:0] cfg_i,
  input  logic [N-1:0]      ie_i,
  input  logic [N-1:0]      invert_i,
  input  logic [FILTW-1:0]  filtlen_i,
  output logic [N-1:0]      z_o,
  output logic [N-1:0]      fault_o
`ifdef LA_IORXDIFF_SYNC_EDGE_EN
  ,
  output logic [N-1:0]      rise_o,
  output logic [N-1:0]      fall_o
`endif
);

  logic [N-1:0] rp, rn;

  for (genvar i = 0; i < N; i++) begin : gen_lane
    la_iobidir #(
      .PROP  (PROP),
      .SIDE  (SIDE),
      .CFGW  (CFGW),
      .RINGW (RINGW)
    ) u_padp (
      .pad_io    (padp_io[i]),
      .vdd_io    (vdd_io),
      .vss_io    (vss_io),
      .vddio_io  (vddio_io),
      .vssio_io  (vssio_io),
      .ioring_io (ioring_io),
      .cfg_i     (cfg_i[i*CFGW +: CFGW]),
      .a_i       (1'b0),
      .oe_i      (1'b0),
      .ie_i      (ie_i[i]),
      .z_o       (rp[i])
    );

    la_iobidir #(
      .PROP  (PROP),
      .SIDE  (SIDE),
      .CFGW  (CFGW),
      .RINGW (RINGW)
    ) u_padn (
      .pad_io    (padn_io[i]),
      .vdd_io    (vdd_io),
      .vss_io    (vss_io),
      .vddio_io  (vddio_io),
      .vssio_io  (vssio_io),
      .ioring_io (ioring_io),
      .cfg_i     (cfg_i[i*CFGW +: CFGW]),
      .a_i       (1'b0),
      .oe_i      (1'b0),
      .ie_i      (ie_i[i]),
      .z_o       (rn[i])
    );

    la_iorxdiff_lane #(
      .SYNC   (SYNC),
      .FILTW  (FILTW),
      .FLTLEN (FLTLEN)
    ) u_lane (
      .clk       (clk),
      .nreset    (nreset),
      .rp_i      (rp[i]),
      .rn_i      (rn[i]),
      .ie_i      (ie_i[i]),
      .invert_i  (invert_i[i]),
      .filtlen_i (filtlen_i),
      .z_o       (z_o[i]),
      .fault_o   (fault_o[i])
`ifdef LA_IORXDIFF_SYNC_EDGE_EN
      ,
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i])
`endif
    );
  end

endmodule

// File: tb/tb_la_iorxdiff_sync.sv
// Scoreboard bench for la_iorxdiff_sync: directed scenarios then randomized
// pad runs, checked against a behavioural model built on delay lines and
// run-length counts.
module tb_la_iorxdiff_sync;

  localparam int N      = 4;
  localparam int SYNC   = 2;
  localparam int FILTW  = 4;
  localparam int FLTLEN = 8;
  localparam int CFGW   = 16;
  localparam int RINGW  = 8;

  logic              clk = 1'b0;
  logic              nreset;
  logic [N-1:0]      padp_drv, padn_drv, ie, invert;
  logic [FILTW-1:0]  filtlen;
  logic [N*CFGW-1:0] cfg;
  logic [N-1:0]      z, fault;
  logic [N-1:0]      rise, fall;

  wire [N-1:0]     padp, padn;
  wire             vdd, vss, vddio, vssio;
  wire [RINGW-1:0] ioring;

  assign padp   = padp_drv;
  assign padn   = padn_drv;
  assign vdd    = 1'b1;
  assign vss    = 1'b0;
  assign vddio  = 1'b1;
  assign vssio  = 1'b0;
  assign ioring = '0;

  always #5 clk = ~clk;

  la_iorxdiff_sync #(
    .N      (N),
    .SYNC   (SYNC),
    .FILTW  (FILTW),
    .FLTLEN (FLTLEN),
    .PROP   ("DEFAULT"),
    .SIDE   ("NO"),
    .CFGW   (CFGW),
    .RINGW  (RINGW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .padp_io   (padp),
    .padn_io   (padn),
    .vdd_io    (vdd),
    .vss_io    (vss),
    .vddio_io  (vddio),
    .vssio_io  (vssio),
    .ioring_io (ioring),
    .cfg_i     (cfg),
    .ie_i      (ie),
    .invert_i  (invert),
    .filtlen_i (filtlen),
    .z_o       (z),
    .fault_o   (fault)
`ifdef LA_IORXDIFF_SYNC_EDGE_EN
    ,
    .rise_o    (rise),
    .fall_o    (fall)
`endif
  );

  typedef struct packed {
    logic [N-1:0] z;
    logic [N-1:0] fault;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: pad samples delayed by SYNC edges, plus run lengths.
  logic [N-1:0] dly_p[$];
  logic [N-1:0] dly_n[$];
  int           diff_run[N];
  int           inv_run[N];
  logic [N-1:0] mz, mf;

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_edge();
    exp_t         e;
    logic [N-1:0] sp, sn, old_z;
    logic         d;
    e = '0;
    if (!nreset) begin
      mz = '0;
      mf = '0;
      for (int i = 0; i < N; i++) begin
        diff_run[i] = 0;
        inv_run[i]  = 0;
      end
      dly_p.delete();
      dly_n.delete();
      for (int s = 0; s < SYNC; s++) begin
        dly_p.push_back('0);
        dly_n.push_back('0);
      end
    end else begin
      sp    = dly_p.pop_front();
      sn    = dly_n.pop_front();
      old_z = mz;
      for (int i = 0; i < N; i++) begin
        if (!ie[i]) begin
          mz[i] = 1'b0;
          mf[i] = 1'b0;
          diff_run[i] = 0;
          inv_run[i]  = 0;
        end else if (sp[i] == sn[i]) begin
          diff_run[i] = 0;
          inv_run[i]  = inv_run[i] + 1;
          mf[i] = (inv_run[i] >= FLTLEN);
        end else begin
          inv_run[i] = 0;
          mf[i] = 1'b0;
          d = sp[i] ^ invert[i];
          if (d != mz[i]) begin
            // z follows once L+1 consecutive differing samples have been seen.
            diff_run[i] = diff_run[i] + 1;
            if (diff_run[i] > int'(filtlen)) begin
              mz[i] = d;
              diff_run[i] = 0;
            end
          end else begin
            diff_run[i] = 0;
          end
        end
        e.rise[i] = ie[i] & ~old_z[i] & mz[i];
        e.fall[i] = ie[i] & old_z[i] & ~mz[i];
      end
      // Disabled pad cells present 0 to the synchronizers.
      dly_p.push_back(padp_drv & ie);
      dly_n.push_back(padn_drv & ie);
    end
    e.z     = mz;
    e.fault = mf;
    expq.push_back(e);
  endtask

  // Monitor: pop one expectation per edge and compare.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow t=%0t: no expectation queued", $time);
    end else begin
      e = expq.pop_front();
      checks++;
      if (z !== e.z) begin
        errors++;
        $display("FAIL z t=%0t got %b want %b", $time, z, e.z);
      end
      checks++;
      if (fault !== e.fault) begin
        errors++;
        $display("FAIL fault t=%0t got %b want %b", $time, fault, e.fault);
      end
`ifdef LA_IORXDIFF_SYNC_EDGE_EN
      checks++;
      if (rise !== e.rise) begin
        errors++;
        $display("FAIL rise t=%0t got %b want %b", $time, rise, e.rise);
      end
      checks++;
      if (fall !== e.fall) begin
        errors++;
        $display("FAIL fall t=%0t got %b want %b", $time, fall, e.fall);
      end
`endif
    end
  end

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      model_edge();
      @(negedge clk);
    end
  endtask

  int   run_left[N];
  int   r, k;

  initial begin
    nreset   = 1'b0;
    padp_drv = '0;
    padn_drv = '0;
    ie       = '1;
    invert   = '0;
    filtlen  = '0;
    cfg      = {$urandom, $urandom};
    rise     = '0;
    fall     = '0;
    for (int i = 0; i < N; i++) run_left[i] = 0;

    // Reset held while pads toggle.
    for (int c = 0; c < 6; c++) begin
      padp_drv = N'($urandom);
      padn_drv = N'($urandom);
      step(1);
    end

    // Release with a stable logic 1 and L=0: z rises on the third edge.
    nreset   = 1'b1;
    padp_drv = '1;
    padn_drv = '0;
    step(6);

    // Glitch of 3 samples with L=3 is swallowed; 4 samples gets through.
    filtlen  = 4'd3;
    padp_drv = '0;
    padn_drv = '1;
    step(3);
    padp_drv = '1;
    padn_drv = '0;
    step(6);
    padp_drv = '0;
    padn_drv = '1;
    step(4);
    step(6);

    // Persistent invalid sets fault, drop ie[2] while faulted, then recover.
    filtlen  = '0;
    padp_drv = '1;
    padn_drv = '1;
    step(11);
    ie[2] = 1'b0;
    step(3);
    ie[2] = 1'b1;
    padn_drv = '0;
    step(6);

    // Polarity swap on a stable input.
    invert = 4'b0101;
    step(5);
    invert = '0;
    step(5);

    // Randomized pad runs with occasional L, invert, ie and reset activity.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (run_left[i] == 0) begin
          r = $urandom_range(0, 9);
          if (r < 4) begin
            padp_drv[i] = 1'b1;
            padn_drv[i] = 1'b0;
          end else if (r < 8) begin
            padp_drv[i] = 1'b0;
            padn_drv[i] = 1'b1;
          end else begin
            padp_drv[i] = (r == 8);
            padn_drv[i] = (r == 8);
          end
          run_left[i] = (r >= 8) ? $urandom_range(1, 12) : $urandom_range(1, 8);
        end
        run_left[i]--;
      end
      if ($urandom_range(0, 39) == 0) begin
        filtlen = ($urandom_range(0, 7) == 0) ? FILTW'($urandom) : FILTW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 99) == 0) begin
        k = $urandom_range(0, N - 1);
        invert[k] = ~invert[k];
      end
      k = $urandom_range(0, N - 1);
      if (ie[k] && $urandom_range(0, 149) == 0) ie[k] = 1'b0;
      else if (!ie[k] && $urandom_range(0, 9) == 0) ie[k] = 1'b1;
      nreset = !(c >= 1500 && c < 1503);
      step(1);
    end

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
